// File: rtl/mips_defs.sv
// Shared MIPS front-end constants: reset vector default, primary opcodes and the canonical NOP.
package mips_defs;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_SEQ      = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Branch/jump target computation and next-PC priority mux (hold > redirect > pc+4).
module pc_next_sel
  import mips_defs::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_plus4_d,
  input  logic [25:0] target_field,
  input  logic        valid_d,
  input  logic        stall,
  input  logic        branch_d,
  input  logic        jump_d,
  input  logic        equal_d,
  output logic [31:0] pc_next,
  output logic [31:0] pc_f_plus4,
  output logic        redirect
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] redir_tgt;
  pc_sel_e     pc_sel;

  always_comb begin
    pc_f_plus4 = pc_f + 32'd4;
    br_tgt     = pc_plus4_d + {{14{target_field[15]}}, target_field[15:0], 2'b00};
    j_tgt      = {pc_plus4_d[31:28], target_field, 2'b00};
    // Jump wins when the decoder raises both.
    redir_tgt  = jump_d ? j_tgt : br_tgt;
    // A stalled branch must not redirect: equal_d may still be based on stale operands.
    redirect   = valid_d & ~stall & (jump_d | (branch_d & equal_d));

    pc_sel = PC_SEQ;
    if (stall)         pc_sel = PC_HOLD;
    else if (redirect) pc_sel = PC_REDIRECT;

    pc_next = pc_f_plus4;
    case (pc_sel)
      PC_HOLD:     pc_next = pc_f;
      PC_REDIRECT: pc_next = redir_tgt;
      default:     pc_next = pc_f_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and redirect/squash control.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DATA_W   = XLEN
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [DATA_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              stall,
  input  logic              flush_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic              equal_d,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_d,
  output logic [DATA_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic [5:0]        op_d,
  output logic [5:0]        funct_d,
  output logic [4:0]        rt_d,
  output logic              redirect
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_f_plus4;

  pc_next_sel u_pc_next_sel (
    .pc_f         (pc_f_q),
    .pc_plus4_d   (ifid_pc4_q),
    .target_field (ifid_instr_q[25:0]),
    .valid_d      (ifid_valid_q),
    .stall        (stall),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .equal_d      (equal_d),
    .pc_next      (pc_f_d),
    .pc_f_plus4   (pc_f_plus4),
    .redirect     (redirect)
  );

  // flush_d beats stall; a redirect squashes the sequential wrong-path word.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (flush_d || (!stall && redirect)) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_instr_d = inst_rdata;
      ifid_pc_d    = pc_f_q;
      ifid_pc4_d   = pc_f_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_f_q       <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign inst_addr  = pc_f_q;
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;
  assign op_d       = ifid_instr_q[31:26];
  assign funct_d    = ifid_instr_q[5:0];
  assign rt_d       = ifid_instr_q[20:16];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the main decoder.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched word into the IF/ID register and presents op/funct/rt slices to the decoder.
- Computes branch/jump targets from the decode-stage instruction and redirects the PC; no branch delay slot, so the wrong-path fetch is squashed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DATA_W, 32, instruction and address width; fixed at 32, no other value supported.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- inst_addr  output  32  instruction memory address; combinational copy of pc_f.
- inst_rdata  input  32  instruction word, combinational read of inst_addr.
- stall  input  1  from hazard unit; holds PC and IF/ID.
- flush_d  input  1  external squash of the IF/ID contents.
- branch_d  input  1  decoder branch output for instr_d.
- jump_d  input  1  decoder jump output for instr_d.
- equal_d  input  1  register-compare result for instr_d (rs == rt).
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  PC of instr_d.
- pc_plus4_d  output  32  pc_d + 4.
- valid_d  output  1  instr_d is a real instruction.
- op_d  output  6  instr_d[31:26].
- funct_d  output  6  instr_d[5:0].
- rt_d  output  5  instr_d[20:16].
- redirect  output  1  PC redirect taken this cycle (combinational).

Behaviour:
- Reset (resetn low, asynchronous): pc_f = RESET_PC, instr_d = 0, pc_d = 0, pc_plus4_d = 0, valid_d = 0. Applies immediately, mid-operation included. First valid_d = 1 appears one cycle after the first rising edge with resetn high.
- redirect = valid_d & ~stall & (jump_d | (branch_d & equal_d)).
- Branch target = pc_plus4_d + {sext(instr_d[15:0]), 2'b00}.
- Jump target = {pc_plus4_d[31:28], instr_d[25:0], 2'b00}.
- If jump_d and branch_d are both high, jump wins.
- PC next-state priority:
  1. stall: hold pc_f.
  2. redirect: selected target.
  3. otherwise: pc_f + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- IF/ID next-state priority:
  1. flush_d: instr_d = 0, valid_d = 0, pc_d/pc_plus4_d = 0. This overrides stall.
  2. stall: hold all IF/ID registers.
  3. redirect: squash as in flush_d; the sequential wrong-path word is discarded.
  4. otherwise: instr_d = inst_rdata, pc_d = pc_f, pc_plus4_d = pc_f + 4, valid_d = 1.
- Stall and redirect conditions: a stalled branch never redirects, because equal_d may depend on unresolved operands. The redirect is taken on the first unstalled cycle.
- Taken-branch penalty: exactly one bubble (one valid_d = 0 cycle).
- Latency: the word at address A appears on instr_d one cycle after pc_f = A.
- Decoded slices are pure wires from instr_d. A squashed slot shows op_d = 0, funct_d = 0 (sll $0 nop), and downstream must gate with valid_d.
- All targets are word-aligned by construction. pc_f[1:0] is always 2'b00 unless RESET_PC is misaligned, which is illegal.

Decomposition:
- Shared package mips_defs: RESET_PC default, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), NOP_INSTR = 32'h0.
- One natural sub-module: pc_next_sel, a combinational target computation plus priority mux. Registers stay in fetch_stage.

Test Plan:
- Reset then run, memory word at each address = its address: after resetn rises, instr_d sequence is 0x0, 0x4, 0x8; valid_d goes 0→1 after the first edge; pc_plus4_d = pc_d + 4.
- BEQ at 0x10 with imm = 0x0003, equal_d = 1: redirect pulses one cycle; pc_f = 0x20; one bubble (valid_d = 0); next instr_d has pc_d = 0x20. Same with equal_d = 0: no redirect, pc_d = 0x14 follows.
- J at 0x3000_0008 with target field 0x0000040: pc_f becomes 0x3000_0100; the 0x3000_000C fetch is squashed.
- stall held 3 cycles while instr_d is BEQ with equal_d = 1: pc_f and instr_d frozen, redirect = 0 throughout; redirect fires on the first cycle stall drops.
- flush_d and stall both high: valid_d = 0 and instr_d = 0 next cycle; pc_f unchanged.
- RESET_PC = 0xFFFF_FFF8: pc_d sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. resetn asserted mid-branch-redirect returns pc_f to RESET_PC immediately with valid_d = 0.
